axis_pkt_scaler: RTL and testbench
==================================

AXIS_PKT_SCALER -- requirements
Module: axis_pkt_scaler

Interface
REQ-001 Parameter DATA_W, default 32, meaning stream data width in bits; SHALL be a multiple of 32, range 32..512.
REQ-002 Parameter MAX_BEATS, default 256, meaning maximum beats forwarded per packet; range 1..65535.
REQ-003 Parameter CNT_W, default 16, meaning beat-counter width; SHALL satisfy 2^CNT_W > MAX_BEATS.
REQ-004 Derived: LANES = DATA_W/32; KEEP_W = DATA_W/8.
REQ-005 Port ap_clk, input, width 1: single clock; all logic is rising-edge.
REQ-006 Port ap_rst, input, width 1: asynchronous, active-high reset.
REQ-007 Ports ap_start (in, 1), ap_done (out, 1), ap_idle (out, 1), ap_ready (out, 1): block-level start/done handshake.
REQ-008 Port mode, input, width 2: operation select; 0 = pass, 1 = wrapping add, 2 = saturating unsigned add, 3 = lane-wise two's-complement negate.
REQ-009 Port bias, input, width 32: addend applied to every 32-bit lane.
REQ-010 Ports A_TDATA (in, DATA_W), A_TVALID (in, 1), A_TREADY (out, 1), A_TKEEP (in, KEEP_W), A_TSTRB (in, KEEP_W), A_TLAST (in, 1): AXI4-Stream slave.
REQ-011 Ports B_TDATA (out, DATA_W), B_TVALID (out, 1), B_TREADY (in, 1), B_TKEEP (out, KEEP_W), B_TSTRB (out, KEEP_W), B_TLAST (out, 1): AXI4-Stream master.
REQ-012 Port beat_count, output, width CNT_W: number of beats forwarded in the last completed packet.
REQ-013 Port trunc, output, width 1: high when the last completed packet exceeded MAX_BEATS.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, DRAIN and FLUSH.
REQ-015 IDLE: ap_idle=1 and A_TREADY=0; when ap_start=1 the block SHALL capture mode and bias, clear the beat counter and enter RUN.
REQ-016 RUN: A_TREADY = NOT skid_full; each accepted beat SHALL be transformed per lane and pushed into the output skid buffer.
REQ-017 Lane transform: pass yields x; wrapping add yields (x+bias) mod 2^32; saturating add yields min(x+bias, 0xFFFFFFFF); negate yields (~x+1) mod 2^32.
REQ-018 TKEEP and TSTRB SHALL pass unchanged, including in null-byte lanes.
REQ-019 Accepted beat at count MAX_BEATS-1 with A_TLAST=0: that beat SHALL be emitted with B_TLAST=1, trunc set, next state DRAIN.
REQ-020 Accepted beat with A_TLAST=1: next state SHALL be FLUSH.
REQ-021 DRAIN: A_TREADY=1; beats SHALL be discarded, without counting, up to and including the A_TLAST beat; then enter FLUSH.
REQ-022 FLUSH: the block SHALL wait until the skid buffer is empty and the TLAST beat has handshaked on B.
REQ-023 On leaving FLUSH, the block SHALL pulse ap_done=1 and ap_ready=1 for exactly one cycle together, update beat_count, and return to IDLE.
REQ-024 Latency: a beat accepted in cycle N SHALL be presented on B no earlier than cycle N+1.
REQ-025 Throughput SHALL be one beat per cycle while B_TREADY=1.
REQ-026 B_TVALID=1 SHALL hold with B_TDATA/TKEEP/TSTRB/TLAST stable until the B handshake completes.
REQ-027 The skid buffer SHALL be 2 entries; simultaneous push and pop while full SHALL NOT be allowed (A_TREADY=0 when full).
REQ-028 ap_start asserted outside IDLE SHALL be ignored; ap_start=1 in the same cycle as ap_done SHALL NOT start a new run, and a new run starts from IDLE on a following cycle.
REQ-029 mode and bias changes during RUN SHALL have no effect.
REQ-030 An incoming single-beat packet SHALL give beat_count=1.
REQ-031 When MAX_BEATS=1, every packet longer than one beat SHALL be truncated.

Reset
REQ-032 While ap_rst=1: FSM=IDLE, skid buffer empty, ap_done=0, ap_ready=0, ap_idle=1, A_TREADY=0, B_TVALID=0, B_TDATA/TKEEP/TSTRB/TLAST=0, beat_count=0, trunc=0.
REQ-033 Reset asserted mid-packet SHALL discard all in-flight beats; B_TVALID SHALL deassert asynchronously and no ap_done SHALL be issued for that packet.

Structure
REQ-034 Package axis_pkt_pkg SHALL hold the state enum, the mode enum (MODE_PASS, MODE_ADD, MODE_SAT, MODE_NEG) and LANE_W=32.
REQ-035 Sub-module axis_skid_buf (parametrised payload width, 2 entries) SHALL implement REQ-026/027; the FSM and lane datapath SHALL stay in the top module.

Verification
REQ-036 DATA_W=32, mode=1, bias=5, 4-beat packet 1,2,3,4, B_TREADY=1 -> B = 6,7,8,9; TLAST on beat 4; ap_done one cycle; beat_count=4; trunc=0.
REQ-037 mode=2, bias=0x10, input 0xFFFFFFF8 -> output 0xFFFFFFFF; mode=3, input 1 -> output 0xFFFFFFFF.
REQ-038 MAX_BEATS=3, 5-beat packet -> 3 beats out with TLAST on the 3rd, 2 beats drained, trunc=1, beat_count=3.
REQ-039 DATA_W=64, B_TREADY toggled 1010... -> no beat lost or duplicated; B payload stable while stalled; A_TREADY=0 only when the skid buffer is full.
REQ-040 ap_rst pulsed after 2 of 6 beats -> B_TVALID=0 immediately, no ap_done; the next ap_start processes a fresh packet correctly.
REQ-041 ap_start held high continuously -> back-to-back packets each produce exactly one ap_done pulse, and ap_idle=1 for at least one cycle between packets.

Source files
------------

// File: rtl/axis_pkt_pkg.sv
// Shared types and the per-lane arithmetic for the packet scaler.
package axis_pkt_pkg;

    localparam int unsigned LANE_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_e;

    typedef enum logic [1:0] {MODE_PASS, MODE_ADD, MODE_SAT, MODE_NEG} mode_e;

    function automatic logic [LANE_W-1:0] lane_op(input mode_e op,
                                                  input logic [LANE_W-1:0] x,
                                                  input logic [LANE_W-1:0] b);
        logic [LANE_W:0]   sum;
        logic [LANE_W-1:0] res;
        sum = {1'b0, x} + {1'b0, b};
        case (op)
            MODE_ADD: res = sum[LANE_W-1:0];
            MODE_SAT: res = sum[LANE_W] ? '1 : sum[LANE_W-1:0];
            MODE_NEG: res = ~x + 1'b1;
            default:  res = x;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer; head entry drives the outputs directly so they stay stable while stalled.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             empty
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             head_vld_q;
    logic             tail_vld_q;
    logic             push;
    logic             pop;

    // Tail is only ever occupied behind a valid head, so both valid means full.
    assign in_ready  = !(head_vld_q && tail_vld_q);
    assign push      = in_valid && in_ready;
    assign pop       = head_vld_q && out_ready;
    assign out_data  = head_q;
    assign out_valid = head_vld_q;
    assign empty     = !head_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else if (pop) begin
            if (tail_vld_q) begin
                head_q     <= tail_q;
                tail_vld_q <= 1'b0;
            end else if (push) begin
                head_q <= in_data;
            end else begin
                head_vld_q <= 1'b0;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_q     <= in_data;
                head_vld_q <= 1'b1;
            end else begin
                tail_q     <= in_data;
                tail_vld_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_scaler.sv
// AXI4-Stream packet scaler: per-lane pass/add/saturate/negate with beat limit and
// block-level start/done handshake.
module axis_pkt_scaler
    import axis_pkt_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BEATS = 256,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [1:0]          mode,
    input  logic [31:0]         bias,
    input  logic [DATA_W-1:0]   A_TDATA,
    input  logic                A_TVALID,
    output logic                A_TREADY,
    input  logic [DATA_W/8-1:0] A_TKEEP,
    input  logic [DATA_W/8-1:0] A_TSTRB,
    input  logic                A_TLAST,
    output logic [DATA_W-1:0]   B_TDATA,
    output logic                B_TVALID,
    input  logic                B_TREADY,
    output logic [DATA_W/8-1:0] B_TKEEP,
    output logic [DATA_W/8-1:0] B_TSTRB,
    output logic                B_TLAST,
    output logic [CNT_W-1:0]    beat_count,
    output logic                trunc
);

    localparam int unsigned LANES  = DATA_W / LANE_W;
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned PAY_W  = DATA_W + 2 * KEEP_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    state_e            state_q;
    mode_e             mode_q;
    logic [31:0]       bias_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              trunc_pend_q;
    logic              done_q;
    logic [CNT_W-1:0]  beat_count_q;
    logic              trunc_q;

    logic [DATA_W-1:0] xform;
    logic [PAY_W-1:0]  skid_in;
    logic [PAY_W-1:0]  skid_out;
    logic              skid_in_ready;
    logic              skid_empty;
    logic              a_hs;
    logic              run_push;
    logic              at_limit;

    assign a_hs     = A_TVALID && A_TREADY;
    assign run_push = (state_q == RUN) && a_hs;
    assign at_limit = (cnt_q == LAST_CNT);
    assign A_TREADY = ((state_q == RUN) && skid_in_ready) || (state_q == DRAIN);

    always_comb begin
        xform = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            xform[i*LANE_W +: LANE_W] = lane_op(mode_q, A_TDATA[i*LANE_W +: LANE_W], bias_q);
        end
    end

    // Forced TLAST marks the final forwarded beat of a truncated packet.
    assign skid_in = {A_TLAST || at_limit, A_TSTRB, A_TKEEP, xform};

    axis_skid_buf #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .in_data  (skid_in),
        .in_valid ((state_q == RUN) && A_TVALID),
        .in_ready (skid_in_ready),
        .out_data (skid_out),
        .out_valid(B_TVALID),
        .out_ready(B_TREADY),
        .empty    (skid_empty)
    );

    assign {B_TLAST, B_TSTRB, B_TKEEP, B_TDATA} = skid_out;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            mode_q       <= MODE_PASS;
            bias_q       <= '0;
            cnt_q        <= '0;
            trunc_pend_q <= 1'b0;
            done_q       <= 1'b0;
            beat_count_q <= '0;
            trunc_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    // A start coinciding with the done pulse is deliberately ignored.
                    if (ap_start && !done_q) begin
                        mode_q       <= mode_e'(mode);
                        bias_q       <= bias;
                        cnt_q        <= '0;
                        trunc_pend_q <= 1'b0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (run_push) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (A_TLAST) begin
                            state_q <= FLUSH;
                        end else if (at_limit) begin
                            trunc_pend_q <= 1'b1;
                            state_q      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (a_hs && A_TLAST) state_q <= FLUSH;
                end
                FLUSH: begin
                    if (skid_empty) begin
                        state_q      <= IDLE;
                        done_q       <= 1'b1;
                        beat_count_q <= cnt_q;
                        trunc_q      <= trunc_pend_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ap_done    = done_q;
    assign ap_ready   = done_q;
    assign ap_idle    = (state_q == IDLE);
    assign beat_count = beat_count_q;
    assign trunc      = trunc_q;

endmodule

// File: tb/tb_axis_pkt_scaler.sv
// Directed bench for axis_pkt_scaler at DATA_W=64, MAX_BEATS=4.
module tb_axis_pkt_scaler;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned KEEP_W    = DATA_W / 8;
    localparam int unsigned MAX_BEATS = 4;
    localparam int unsigned CNT_W     = 16;

    logic              ap_clk;
    logic              ap_rst;
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [1:0]        mode;
    logic [31:0]       bias;
    logic [DATA_W-1:0] A_TDATA;
    logic              A_TVALID;
    logic              A_TREADY;
    logic [KEEP_W-1:0] A_TKEEP;
    logic [KEEP_W-1:0] A_TSTRB;
    logic              A_TLAST;
    logic [DATA_W-1:0] B_TDATA;
    logic              B_TVALID;
    logic              B_TREADY;
    logic [KEEP_W-1:0] B_TKEEP;
    logic [KEEP_W-1:0] B_TSTRB;
    logic              B_TLAST;
    logic [CNT_W-1:0]  beat_count;
    logic              trunc;

    axis_pkt_scaler #(
        .DATA_W   (DATA_W),
        .MAX_BEATS(MAX_BEATS),
        .CNT_W    (CNT_W)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .mode      (mode),
        .bias      (bias),
        .A_TDATA   (A_TDATA),
        .A_TVALID  (A_TVALID),
        .A_TREADY  (A_TREADY),
        .A_TKEEP   (A_TKEEP),
        .A_TSTRB   (A_TSTRB),
        .A_TLAST   (A_TLAST),
        .B_TDATA   (B_TDATA),
        .B_TVALID  (B_TVALID),
        .B_TREADY  (B_TREADY),
        .B_TKEEP   (B_TKEEP),
        .B_TSTRB   (B_TSTRB),
        .B_TLAST   (B_TLAST),
        .beat_count(beat_count),
        .trunc     (trunc)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [KEEP_W-1:0] k;
        logic [KEEP_W-1:0] s;
        logic              l;
    } beat_t;

    beat_t             rx_q[$];
    int                done_cnt   = 0;
    logic              prev_done  = 1'b0;
    logic              prev_stall = 1'b0;
    beat_t             prev_beat;
    logic              stab_en    = 1'b0;
    logic              occ_en     = 1'b0;
    int                occ        = 0;
    logic              tog_en     = 1'b0;

    logic [DATA_W-1:0] tx_data [16];
    logic [KEEP_W-1:0] tx_keep [16];
    logic [KEEP_W-1:0] tx_strb [16];
    logic [DATA_W-1:0] exp_data[16];

    // Output monitor and per-cycle protocol checks, sampled mid-cycle.
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (B_TVALID && B_TREADY) rx_q.push_back({B_TDATA, B_TKEEP, B_TSTRB, B_TLAST});
            if (ap_done) done_cnt++;
            if (ap_done || ap_ready) check_eq("ready_with_done", ap_ready, ap_done);
            if (ap_done) check_eq("done_single_cycle", prev_done, 1'b0);
            if (stab_en && prev_stall) begin
                check_eq("stall_valid_held", B_TVALID, 1'b1);
                check_eq("stall_payload_held", {B_TDATA, B_TKEEP, B_TSTRB, B_TLAST}, prev_beat);
            end
            if (occ_en) begin
                if (A_TVALID) check_eq("a_tready_vs_occupancy", A_TREADY, occ < 2);
                occ = occ + int'(A_TVALID && A_TREADY) - int'(B_TVALID && B_TREADY);
            end
            prev_stall = B_TVALID && !B_TREADY;
            prev_beat  = {B_TDATA, B_TKEEP, B_TSTRB, B_TLAST};
            prev_done  = ap_done;
        end
    end

    always @(posedge ap_clk) begin
        if (tog_en) begin
            #1;
            B_TREADY = ~B_TREADY;
        end
    end

    task automatic wait_a_hs();
        int t = 0;
        @(negedge ap_clk);
        while (!A_TREADY && t < 100) begin
            @(negedge ap_clk);
            t++;
        end
        if (!A_TREADY) check_eq("a_handshake_timeout", A_TREADY, 1'b1);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_beats(input int first, input int cnt, input int total);
        for (int i = first; i < first + cnt; i++) begin
            A_TDATA  = tx_data[i];
            A_TKEEP  = tx_keep[i];
            A_TSTRB  = tx_strb[i];
            A_TLAST  = (i == total - 1);
            A_TVALID = 1'b1;
            wait_a_hs();
        end
        A_TVALID = 1'b0;
        A_TLAST  = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] b);
        mode     = m;
        bias     = b;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
    endtask

    task automatic wait_done();
        int t  = 0;
        int d0 = done_cnt;
        @(negedge ap_clk);
        while (!ap_done && t < 200) begin
            @(negedge ap_clk);
            t++;
        end
        check_eq("done_seen", ap_done, 1'b1);
        repeat (3) @(posedge ap_clk);
        #1;
        check_eq("done_pulse_count", done_cnt - d0, 1);
    endtask

    task automatic check_out(input int n);
        check_eq("rx_beat_count", rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            check_eq($sformatf("b_data[%0d]", i), rx_q[i].d, exp_data[i]);
            check_eq($sformatf("b_keep[%0d]", i), rx_q[i].k, tx_keep[i]);
            check_eq($sformatf("b_strb[%0d]", i), rx_q[i].s, tx_strb[i]);
            check_eq($sformatf("b_last[%0d]", i), rx_q[i].l, i == n - 1);
        end
        rx_q.delete();
    endtask

    initial begin
        int t;
        int d0;
        ap_rst   = 1'b1;
        ap_start = 1'b0;
        mode     = 2'd0;
        bias     = '0;
        A_TDATA  = '0;
        A_TVALID = 1'b0;
        A_TKEEP  = '0;
        A_TSTRB  = '0;
        A_TLAST  = 1'b0;
        B_TREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_keep[i] = KEEP_W'(8'hA5 ^ i);
            tx_strb[i] = KEEP_W'(8'h3C + i * 7);
        end

        // Reset state
        #12;
        check_eq("rst_idle", ap_idle, 1'b1);
        check_eq("rst_done", ap_done, 1'b0);
        check_eq("rst_ready", ap_ready, 1'b0);
        check_eq("rst_a_tready", A_TREADY, 1'b0);
        check_eq("rst_b_tvalid", B_TVALID, 1'b0);
        check_eq("rst_b_payload", {B_TDATA, B_TKEEP, B_TSTRB, B_TLAST}, '0);
        check_eq("rst_beat_count", beat_count, '0);
        check_eq("rst_trunc", trunc, 1'b0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        check_eq("idle_a_tready", A_TREADY, 1'b0);

        // Wrapping add, bias 5; mode/bias changed mid-run must be ignored
        tx_data[0] = 64'hFFFFFFFB_00000001;  exp_data[0] = 64'h00000000_00000006;
        tx_data[1] = 64'hFFFFFFFC_00000002;  exp_data[1] = 64'h00000001_00000007;
        tx_data[2] = 64'hFFFFFFFD_00000003;  exp_data[2] = 64'h00000002_00000008;
        tx_data[3] = 64'hFFFFFFFE_00000004;  exp_data[3] = 64'h00000003_00000009;
        start_run(2'd1, 32'd5);
        mode = 2'd3;
        bias = 32'h1234;
        send_beats(0, 4, 4);
        wait_done();
        check_out(4);
        check_eq("add_beat_count", beat_count, 4);
        check_eq("add_trunc", trunc, 1'b0);

        // Saturating add, single beat
        tx_data[0] = 64'hFFFFFFEE_FFFFFFF8;  exp_data[0] = 64'hFFFFFFFE_FFFFFFFF;
        start_run(2'd2, 32'h10);
        send_beats(0, 1, 1);
        wait_done();
        check_out(1);
        check_eq("sat_beat_count", beat_count, 1);

        // Negate
        tx_data[0] = 64'h00000002_00000001;  exp_data[0] = 64'hFFFFFFFE_FFFFFFFF;
        start_run(2'd3, 32'd5);
        send_beats(0, 1, 1);
        wait_done();
        check_out(1);

        // Pass with nonzero bias
        tx_data[0] = 64'hDEADBEEF_12345678;  exp_data[0] = 64'hDEADBEEF_12345678;
        start_run(2'd0, 32'd7);
        send_beats(0, 1, 1);
        wait_done();
        check_out(1);

        // Truncation: 6-beat packet, 4 forwarded, 2 drained
        for (int i = 0; i < 6; i++) begin
            tx_data[i]  = 64'h1000_0000_0000_0000 + 64'(i);
            exp_data[i] = tx_data[i];
        end
        start_run(2'd0, 32'd0);
        send_beats(0, 6, 6);
        wait_done();
        check_out(4);
        check_eq("trunc_beat_count", beat_count, 4);
        check_eq("trunc_flag", trunc, 1'b1);

        // Backpressure: B_TREADY toggles every cycle
        for (int i = 0; i < 4; i++) begin
            tx_data[i]  = {32'hFFFFFFFF - 32'(i), 32'h100 * 32'(i + 1)};
            exp_data[i] = {32'h0 - 32'(i), 32'h100 * 32'(i + 1) + 32'h1};
        end
        occ     = 0;
        occ_en  = 1'b1;
        stab_en = 1'b1;
        tog_en  = 1'b1;
        start_run(2'd1, 32'd1);
        send_beats(0, 4, 4);
        wait_done();
        tog_en  = 1'b0;
        stab_en = 1'b0;
        occ_en  = 1'b0;
        @(posedge ap_clk);
        #1;
        B_TREADY = 1'b1;
        check_out(4);
        check_eq("stall_beat_count", beat_count, 4);
        check_eq("stall_trunc_cleared", trunc, 1'b0);

        // Reset mid-packet
        B_TREADY = 1'b0;
        for (int i = 0; i < 6; i++) tx_data[i] = 64'(i + 1);
        start_run(2'd1, 32'd5);
        send_beats(0, 2, 6);
        check_eq("pre_rst_b_tvalid", B_TVALID, 1'b1);
        d0 = done_cnt;
        #2;
        ap_rst = 1'b1;
        #1;
        check_eq("rst_mid_b_tvalid", B_TVALID, 1'b0);
        check_eq("rst_mid_idle", ap_idle, 1'b1);
        #3;
        ap_rst = 1'b0;
        @(posedge ap_clk);
        #1;
        rx_q.delete();
        B_TREADY = 1'b1;
        repeat (4) @(posedge ap_clk);
        #1;
        check_eq("rst_mid_no_done", done_cnt - d0, 0);
        check_eq("rst_mid_b_quiet", rx_q.size(), 0);
        tx_data[0] = 64'h00000000_00000005;  exp_data[0] = 64'h00000000_FFFFFFFB;
        tx_data[1] = 64'hFFFFFFFF_80000000;  exp_data[1] = 64'h00000001_80000000;
        start_run(2'd3, 32'd0);
        send_beats(0, 2, 2);
        wait_done();
        check_out(2);
        check_eq("post_rst_beat_count", beat_count, 2);

        // ap_start held high across back-to-back packets
        tx_data[0] = 64'hAAAA0000_BBBB0001;  exp_data[0] = tx_data[0];
        tx_data[1] = 64'hAAAA0002_BBBB0003;  exp_data[1] = tx_data[1];
        d0       = done_cnt;
        mode     = 2'd0;
        bias     = '0;
        ap_start = 1'b1;
        for (int p = 0; p < 2; p++) begin
            send_beats(0, 2 - p, 2 - p);
            t = 0;
            @(negedge ap_clk);
            while (!ap_done && t < 200) begin
                @(negedge ap_clk);
                t++;
            end
            check_eq("held_done_seen", ap_done, 1'b1);
            check_eq("held_idle_at_done", ap_idle, 1'b1);
            if (p == 1) ap_start = 1'b0;
            @(negedge ap_clk);
            check_eq("held_done_dropped", ap_done, 1'b0);
            check_eq("held_idle_gap", ap_idle, 1'b1);
            @(negedge ap_clk);
            check_eq("held_restart", ap_idle, p == 1);
            check_out(2 - p);
            check_eq("held_beat_count", beat_count, 2 - p);
            @(posedge ap_clk);
            #1;
        end
        repeat (3) @(posedge ap_clk);
        #1;
        check_eq("held_done_total", done_cnt - d0, 2);
        check_eq("held_final_idle", ap_idle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
